// File: rtl/prng_share_pkg.sv
// Shared types, constants and the round-robin pick helper for the PRNG share arbiter.
// Combinational helpers only; no state lives here.
// rr_pick searches a request mask upward from a pointer with wrap at n.
package prng_share_pkg;

  typedef enum logic [1:0] {
    RESEED = 2'd0,
    WARMUP = 2'd1,
    SERVE  = 2'd2
  } state_e;

  localparam logic [31:0] SEED_DEFAULT_C = 32'hACE1_0001;
  localparam int          WARMUP_CNT_W   = 4;
  localparam int          RR_MAX         = 8;

  // First set bit of mask at or after ptr, wrapping at n; 0 when mask is empty.
  function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] mask,
                                         input logic [2:0]        ptr,
                                         input int                n);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = 3'd0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = (int'(ptr) + i) % n;
      if ((i < n) && !found && mask[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/prng_share_arbiter_rr_arbiter_core.sv
// Round-robin pick over NUM_REQ requests plus the rotating priority pointer.
// Pick is combinational; pointer updates on the edge where adv is high.
// No backpressure: caller decides when a pick is consumed via adv.
module rr_arbiter_core
  import prng_share_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic               any_req,
  output logic [2:0]         winner
);

  logic [2:0]        rr_ptr_q;
  logic [2:0]        rr_ptr_d;
  logic [RR_MAX-1:0] mask;

  // Widen the request vector and pick the winner from the current pointer.
  always_comb begin
    mask               = '0;
    mask[NUM_REQ-1:0]  = req;
    any_req            = |req;
    winner             = rr_pick(mask, rr_ptr_q, NUM_REQ);
  end

  // Pointer moves to just past the winner when the grant is taken.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (adv) begin
      rr_ptr_d = (int'(winner) == NUM_REQ - 1) ? 3'd0 : (winner + 3'd1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= 3'd0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/prng_share_arbiter.sv
// Shares one PCG generator among NUM_REQ consumers; sequences reseed and warm-up.
// req->gnt latency 1 cycle; rnd_out is the generator word seen at the decision edge.
// One grant per cycle; a pending seed_load pre-empts any new grant. Optional macro: PRNG_SHARE_ARB_REPEAT_CHK_EN.
module prng_share_arbiter
  import prng_share_pkg::*;
#(
  parameter int          NUM_REQ       = 4,
  parameter int          WARMUP_CYCLES = 2,
  parameter logic [31:0] SEED_DEFAULT  = SEED_DEFAULT_C
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        seed_in,
  input  logic               seed_load,
  output logic               gen_rst,
  output logic [31:0]        gen_seed,
  input  logic [31:0]        gen_data,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
`ifdef PRNG_SHARE_ARB_REPEAT_CHK_EN
  output logic               repeat_err,
`endif
  output logic [31:0]        rnd_out,
  output logic               rnd_valid,
  output logic               ready
);

  localparam logic [WARMUP_CNT_W-1:0] WARM_LAST = WARMUP_CNT_W'(WARMUP_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [31:0]             seed_q, seed_d;
  logic                    gen_rst_q, gen_rst_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [31:0]             rnd_q, rnd_d;
  logic                    ready_q, ready_d;
  logic [WARMUP_CNT_W-1:0] warm_cnt_q, warm_cnt_d;

  logic                    any_req;
  logic [2:0]              winner;
  logic                    adv;

`ifdef PRNG_SHARE_ARB_REPEAT_CHK_EN
  logic [31:0]             last_q, last_d;
  logic                    last_vld_q, last_vld_d;
  logic                    rep_err_q, rep_err_d;
`endif

  rr_arbiter_core #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .adv     (adv),
    .any_req (any_req),
    .winner  (winner)
  );

  // Next-state: seed_load overrides everything; grants only issue in SERVE.
  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    warm_cnt_d = warm_cnt_q;
    gnt_d      = '0;
    rnd_d      = rnd_q;
    adv        = 1'b0;
`ifdef PRNG_SHARE_ARB_REPEAT_CHK_EN
    last_d     = last_q;
    last_vld_d = last_vld_q;
    rep_err_d  = rep_err_q;
`endif
    if (seed_load) begin
      seed_d     = seed_in;
      state_d    = RESEED;
      warm_cnt_d = '0;
`ifdef PRNG_SHARE_ARB_REPEAT_CHK_EN
      last_vld_d = 1'b0;
      rep_err_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        RESEED: begin
          state_d    = WARMUP;
          warm_cnt_d = '0;
        end
        WARMUP: begin
          if (warm_cnt_q == WARM_LAST) begin
            state_d    = SERVE;
            warm_cnt_d = '0;
          end else begin
            warm_cnt_d = warm_cnt_q + 1'b1;
          end
        end
        SERVE: begin
          if (any_req) begin
            adv   = 1'b1;
            rnd_d = gen_data;
            for (int i = 0; i < NUM_REQ; i++) begin
              gnt_d[i] = (winner == 3'(i));
            end
`ifdef PRNG_SHARE_ARB_REPEAT_CHK_EN
            if (last_vld_q && (gen_data == last_q)) rep_err_d = 1'b1;
            last_d     = gen_data;
            last_vld_d = 1'b1;
`endif
          end
        end
        default: state_d = RESEED;
      endcase
    end
    // Generator reset is held exactly while the FSM sits in RESEED.
    gen_rst_d = (state_d == RESEED);
    ready_d   = (state_d == SERVE);
  end

  // All FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESEED;
      seed_q     <= SEED_DEFAULT;
      gen_rst_q  <= 1'b1;
      gnt_q      <= '0;
      rnd_q      <= '0;
      ready_q    <= 1'b0;
      warm_cnt_q <= '0;
`ifdef PRNG_SHARE_ARB_REPEAT_CHK_EN
      last_q     <= '0;
      last_vld_q <= 1'b0;
      rep_err_q  <= 1'b0;
`else
      // No repeat tracking state in this build.
`endif
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      gen_rst_q  <= gen_rst_d;
      gnt_q      <= gnt_d;
      rnd_q      <= rnd_d;
      ready_q    <= ready_d;
      warm_cnt_q <= warm_cnt_d;
`ifdef PRNG_SHARE_ARB_REPEAT_CHK_EN
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      rep_err_q  <= rep_err_d;
`endif
    end
  end

  assign gen_rst   = gen_rst_q;
  assign gen_seed  = seed_q;
  assign gnt       = gnt_q;
  assign rnd_out   = rnd_q;
  assign rnd_valid = |gnt_q;
  assign ready     = ready_q;
`ifdef PRNG_SHARE_ARB_REPEAT_CHK_EN
  assign repeat_err = rep_err_q;
`endif

endmodule

// File: tb/tb_prng_share_arbiter.sv
// Directed bench for prng_share_arbiter with a local PCG-style generator model.
module tb_prng_share_arbiter;

  localparam logic [31:0] SEED_DEF = 32'hACE1_0001;
  localparam logic [31:0] SEED_NEW = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] seed_in = '0;
  logic        seed_load = 1'b0;
  logic        gen_rst;
  logic [31:0] gen_seed;
  logic [31:0] gen_data;
  logic [3:0]  req = '0;
  logic [3:0]  gnt;
  logic [31:0] rnd_out;
  logic        rnd_valid;
  logic        ready;
`ifdef PRNG_SHARE_ARB_REPEAT_CHK_EN
  logic        repeat_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prng_share_arbiter #(
    .NUM_REQ       (4),
    .WARMUP_CYCLES (2),
    .SEED_DEFAULT  (SEED_DEF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_in    (seed_in),
    .seed_load  (seed_load),
    .gen_rst    (gen_rst),
    .gen_seed   (gen_seed),
    .gen_data   (gen_data),
    .req        (req),
    .gnt        (gnt),
`ifdef PRNG_SHARE_ARB_REPEAT_CHK_EN
    .repeat_err (repeat_err),
`endif
    .rnd_out    (rnd_out),
    .rnd_valid  (rnd_valid),
    .ready      (ready)
  );

  // ---- generator model ----
  function automatic logic [31:0] lcg(input logic [31:0] x);
    return x * 32'd747796405 + 32'd2891336453;
  endfunction

  function automatic logic [31:0] perm(input logic [31:0] x);
    logic [31:0] y;
    logic [63:0] yy;
    y  = x ^ (x >> 16);
    yy = {y, y} >> x[31:27];
    return yy[31:0];
  endfunction

  // k-th delivered word after a reseed (two outputs are discarded by warm-up).
  function automatic logic [31:0] model_word(input logic [31:0] seed, input int k);
    logic [31:0] s;
    s = seed;
    for (int i = 0; i < k; i++) s = lcg(s);
    return perm(s);
  endfunction

  logic [31:0] g_st, g_out;
  logic        gen_force = 1'b0;

  always @(posedge clk) begin
    if (gen_rst) begin
      g_st  <= gen_seed;
      g_out <= '0;
    end else begin
      g_st  <= lcg(g_st);
      g_out <= perm(g_st);
    end
  end

  assign gen_data = gen_force ? 32'hDEAD_BEEF : g_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
  } vec_t;

  vec_t        tbl[16];
  logic [31:0] exp_rnd;
  int          word_idx;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end by 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    // rr_ptr starts at 0; expected grants hand-derived from the rotating pointer.
    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001};
    tbl[5]  = '{4'b1111, 4'b0010};
    tbl[6]  = '{4'b1111, 4'b0100};
    tbl[7]  = '{4'b1111, 4'b1000};
    tbl[8]  = '{4'b0100, 4'b0100};
    tbl[9]  = '{4'b0100, 4'b0100};
    tbl[10] = '{4'b0100, 4'b0100};
    tbl[11] = '{4'b0000, 4'b0000};
    tbl[12] = '{4'b1001, 4'b1000};
    tbl[13] = '{4'b0110, 4'b0010};
    tbl[14] = '{4'b0011, 4'b0001};
    tbl[15] = '{4'b1010, 4'b0010};

    // ---- reset values and release ----
    repeat (2) @(negedge clk);
    chk("rst_gen_rst", {31'b0, gen_rst}, 32'd1);
    chk("rst_gen_seed", gen_seed, SEED_DEF);
    chk("rst_gnt", {28'b0, gnt}, 32'd0);
    chk("rst_rnd_out", rnd_out, 32'd0);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_gen_rst", {31'b0, gen_rst}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("warm%0d_ready", k), {31'b0, ready}, (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("warm%0d_gnt", k), {28'b0, gnt}, 32'd0);
      chk($sformatf("warm%0d_gen_rst", k), {31'b0, gen_rst}, 32'd0);
    end

    // ---- table vectors, one SERVE cycle each ----
    exp_rnd  = '0;
    word_idx = 0;
    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req;
      word_idx++;
      @(posedge clk); #1;
      if (tbl[i].gnt != 4'b0000) exp_rnd = model_word(SEED_DEF, word_idx);
      chk($sformatf("vec%0d_gnt", i), {28'b0, gnt}, {28'b0, tbl[i].gnt});
      chk($sformatf("vec%0d_valid", i), {31'b0, rnd_valid}, {31'b0, |tbl[i].gnt});
      chk($sformatf("vec%0d_rnd", i), rnd_out, exp_rnd);
    end

    // ---- seed_load while everyone requests; pointer is at 2 ----
    req       = 4'b1111;
    seed_in   = SEED_NEW;
    seed_load = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0;
    chk("sl_gnt", {28'b0, gnt}, 32'd0);
    chk("sl_valid", {31'b0, rnd_valid}, 32'd0);
    chk("sl_gen_rst", {31'b0, gen_rst}, 32'd1);
    chk("sl_gen_seed", gen_seed, SEED_NEW);
    chk("sl_ready", {31'b0, ready}, 32'd0);
    chk("sl_rnd_hold", rnd_out, exp_rnd);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sl_warm%0d_gnt", k), {28'b0, gnt}, 32'd0);
      chk($sformatf("sl_warm%0d_gen_rst", k), {31'b0, gen_rst}, 32'd0);
      chk($sformatf("sl_warm%0d_ready", k), {31'b0, ready}, (k == 3) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    chk("rs1_gnt", {28'b0, gnt}, 32'b0100);
    chk("rs1_rnd", rnd_out, model_word(SEED_NEW, 1));
    @(posedge clk); #1;
    chk("rs2_gnt", {28'b0, gnt}, 32'b1000);
    chk("rs2_rnd", rnd_out, model_word(SEED_NEW, 2));
    @(posedge clk); #1;
    chk("rs3_gnt", {28'b0, gnt}, 32'b0001);
    chk("rs3_rnd", rnd_out, model_word(SEED_NEW, 3));

    // ---- asynchronous reset between edges while a grant is showing ----
    #3;
    rst = 1'b1;
    #1;
    chk("arst_gnt", {28'b0, gnt}, 32'd0);
    chk("arst_valid", {31'b0, rnd_valid}, 32'd0);
    chk("arst_ready", {31'b0, ready}, 32'd0);
    chk("arst_gen_rst", {31'b0, gen_rst}, 32'd1);
    chk("arst_gen_seed", gen_seed, SEED_DEF);
    chk("arst_rnd", rnd_out, 32'd0);
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rerel_ready", {31'b0, ready}, 32'd1);

`ifdef PRNG_SHARE_ARB_REPEAT_CHK_EN
    // ---- repeated word detection ----
    chk("rep_init", {31'b0, repeat_err}, 32'd0);
    gen_force = 1'b1;
    req       = 4'b0001;
    @(posedge clk); #1;
    chk("rep_g1_gnt", {28'b0, gnt}, 32'b0001);
    chk("rep_g1_rnd", rnd_out, 32'hDEAD_BEEF);
    chk("rep_g1_err", {31'b0, repeat_err}, 32'd0);
    @(posedge clk); #1;
    chk("rep_g2_err", {31'b0, repeat_err}, 32'd1);
    req       = 4'b0000;
    gen_force = 1'b0;
    @(posedge clk); #1;
    chk("rep_sticky", {31'b0, repeat_err}, 32'd1);
    seed_in   = SEED_NEW;
    seed_load = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0;
    chk("rep_clear", {31'b0, repeat_err}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
